video_pattern_source: RTL and testbench

Pixel-clock test-pattern generator that sits directly upstream of the hdmi core and drives its rgb input from the cx/cy counters the core returns. Produces four selectable patterns: border, colour bars, gradient and bouncing box. Supports manual selection or automatic cycling every N frames. Exposes the current pattern and a frame counter for debug and bench checking.

---
 rtl/video_pattern_source.sv | 98 +++++++++
 tb/tb_video_pattern_source.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/video_pattern_source.sv
// video_pattern_source: pixel-clock test-pattern generator feeding the hdmi core rgb input.
// Ports:
//   clk_pixel   pixel clock, the only clock
//   reset       asynchronous active-high reset
//   cx, cy      current pixel position returned by the hdmi core
//   auto_cycle  1 rotates patterns every FRAMES_PER_PATTERN frames, 0 follows mode_select
//   mode_select requested pattern in manual mode
//   rgb         registered {R,G,B}, one cycle after cx/cy
//   pattern     pattern currently drawn (0 border, 1 bars, 2 gradient, 3 box)
//   frame_count frames started since reset, wraps at 16 bits
module video_pattern_source #(
    parameter int BIT_WIDTH          = 10,
    parameter int FRAME_WIDTH        = 858,
    parameter int FRAME_HEIGHT       = 525,
    parameter int SCREEN_WIDTH       = 720,
    parameter int SCREEN_HEIGHT      = 480,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int BOX_SIZE           = 32
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] cx,
    input  logic [BIT_WIDTH-1:0] cy,
    input  logic                 auto_cycle,
    input  logic [1:0]           mode_select,
    output logic [23:0]          rgb,
    output logic [1:0]           pattern,
    output logic [15:0]          frame_count
);
    localparam logic [BIT_WIDTH-1:0] SX   = BIT_WIDTH'(FRAME_WIDTH - SCREEN_WIDTH);
    localparam logic [BIT_WIDTH-1:0] SY   = BIT_WIDTH'(FRAME_HEIGHT - SCREEN_HEIGHT);
    localparam logic [BIT_WIDTH-1:0] XEND = BIT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0] YEND = BIT_WIDTH'(FRAME_HEIGHT - 1);
    localparam logic [BIT_WIDTH-1:0] XMAX = BIT_WIDTH'(SCREEN_WIDTH - BOX_SIZE);
    localparam logic [BIT_WIDTH-1:0] YMAX = BIT_WIDTH'(SCREEN_HEIGHT - BOX_SIZE);
    localparam int BAR = SCREEN_WIDTH / 8;
    localparam int CW = $clog2(FRAMES_PER_PATTERN + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_PATTERN - 1);
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic [CW-1:0] fip;
    logic [BIT_WIDTH-1:0] bx, by, xr, yr;
    logic dx_neg, dy_neg, fs, active, box, x_turn, y_turn;
    logic [2:0] bar;
    logic [23:0] pix;

    assign fs     = cx == '0 && cy == '0;
    assign active = cx >= SX && cy >= SY;
    assign xr     = cx - SX;
    assign yr     = cy - SY;
    // a direction flips when the box sits on the wall it is heading toward
    assign x_turn = dx_neg ? bx == '0 : bx == XMAX;
    assign y_turn = dy_neg ? by == '0 : by == YMAX;

    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++)
            if (int'(xr) >= i * BAR) bar = bar + 3'd1;
        box = xr >= bx && int'(xr) < int'(bx) + BOX_SIZE && yr >= by && int'(yr) < int'(by) + BOX_SIZE;
        pix = pattern == 2'd0 ? {{8{cx == SX}}, {8{cy == SY}}, {8{cx == XEND || cy == YEND}}} :
              pattern == 2'd1 ? BARS[bar] :
              pattern == 2'd2 ? {3{xr[7:0]}} :
              {24{box}};
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            rgb         <= '0;
            pattern     <= '0;
            frame_count <= '0;
            fip         <= '0;
            bx          <= '0;
            by          <= '0;
            dx_neg      <= 1'b0;
            dy_neg      <= 1'b0;
        end else begin
            rgb <= active ? pix : '0;
            if (fs) begin
                frame_count <= frame_count + 16'd1;
                if (!auto_cycle) begin
                    pattern <= mode_select;
                    fip     <= '0;
                end else if (fip == LAST) begin
                    pattern <= pattern + 2'd1;
                    fip     <= '0;
                end else begin
                    fip <= fip + CW'(1);
                end
                // step follows the post-flip direction, so a wall hit moves one pixel back
                dx_neg <= dx_neg ^ x_turn;
                dy_neg <= dy_neg ^ y_turn;
                bx     <= (dx_neg ^ x_turn) ? bx - 1'b1 : bx + 1'b1;
                by     <= (dy_neg ^ y_turn) ? by - 1'b1 : by + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_video_pattern_source.sv
// tb_video_pattern_source: randomized and directed checks of video_pattern_source against a behavioural model.
module tb_video_pattern_source;
    localparam int SX = 138, SY = 45, XMAX = 688, YMAX = 448, FPP = 2;

    logic clk_pixel = 1'b0, reset = 1'b1, auto_cycle = 1'b0;
    logic [9:0] cx = '0, cy = '0;
    logic [1:0] mode_select = '0;
    logic [23:0] rgb;
    logic [1:0] pattern;
    logic [15:0] frame_count;

    int vectors = 0, errors = 0;
    int m_fc = 0, m_pat = 0, m_k = 0, m_fs = 0;
    int bars [8] = '{'hFFFFFF, 'hFFFF00, 'h00FFFF, 'h00FF00, 'hFF00FF, 'hFF0000, 'h0000FF, 0};
    int pseq [9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};

    video_pattern_source #(.FRAMES_PER_PATTERN(FPP)) dut (
        .clk_pixel(clk_pixel), .reset(reset), .cx(cx), .cy(cy),
        .auto_cycle(auto_cycle), .mode_select(mode_select),
        .rgb(rgb), .pattern(pattern), .frame_count(frame_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    // box position as a triangle wave of the number of frame starts
    function automatic int tri_pos(int n, int m);
        int p;
        p = n % (2 * m);
        return p <= m ? p : 2 * m - p;
    endfunction

    function automatic int pix(int x, int y);
        int xr, yr, bx, by;
        if (x < SX || y < SY) return 0;
        xr = x - SX;
        yr = y - SY;
        bx = tri_pos(m_fs, XMAX);
        by = tri_pos(m_fs, YMAX);
        if (m_pat == 0) return (x == SX ? 'hFF0000 : 0) | (y == SY ? 'h00FF00 : 0) | ((x == 857 || y == 524) ? 'hFF : 0);
        if (m_pat == 1) return bars[xr / 90];
        if (m_pat == 2) return (xr % 256) * 'h010101;
        return (xr >= bx && xr < bx + 32 && yr >= by && yr < by + 32) ? 'hFFFFFF : 0;
    endfunction

    task automatic check(string n, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic cyc(int x, int y, bit ac, int ms);
        int e;
        cx = 10'(x);
        cy = 10'(y);
        auto_cycle = ac;
        mode_select = 2'(ms);
        @(posedge clk_pixel);
        e = pix(x, y);
        if (x == 0 && y == 0) begin
            m_fc = (m_fc + 1) % 65536;
            m_fs++;
            if (!ac) begin
                m_pat = ms;
                m_k = 0;
            end else if (m_k == FPP - 1) begin
                m_pat = (m_pat + 1) % 4;
                m_k = 0;
            end else m_k++;
        end
        @(negedge clk_pixel);
        check("rgb", rgb, e);
        check("pattern", pattern, m_pat);
        check("frame_count", frame_count, m_fc);
    endtask

    task automatic lit(string n, int x, int y, bit ac, int ms, int want);
        cyc(x, y, ac, ms);
        check(n, rgb, want);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_rgb", rgb, 0);
        check("rst_pattern", pattern, 0);
        check("rst_frame_count", frame_count, 0);
        m_fc = 0; m_pat = 0; m_k = 0; m_fs = 0;
        #1 reset = 1'b0;
    endtask

    initial begin
        bit ac, done;
        int x, y;
        #3;
        check("por_rgb", rgb, 0);
        check("por_pattern", pattern, 0);
        check("por_frame_count", frame_count, 0);
        @(negedge clk_pixel);
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        lit("border_r", 138, 100, 0, 0, 'hFF0000);
        lit("border_g", 300, 45, 0, 0, 'h00FF00);
        lit("border_b_x", 857, 200, 0, 0, 'h0000FF);
        lit("border_b_y", 400, 524, 0, 0, 'h0000FF);
        lit("border_corner", 138, 45, 0, 0, 'hFFFF00);
        lit("border_blank", 100, 100, 0, 0, 0);
        cyc(0, 0, 0, 1);
        lit("bar_89", 227, 200, 0, 1, 'hFFFFFF);
        lit("bar_90", 228, 200, 0, 1, 'hFFFF00);
        lit("bar_629", 767, 200, 0, 1, 'h0000FF);
        lit("bar_630", 768, 200, 0, 1, 0);
        lit("bar_outside", 137, 200, 0, 1, 0);
        cyc(0, 0, 0, 0);
        lit("mid_hold", 138, 300, 0, 2, 'hFF0000);
        cyc(500, 300, 0, 2);
        cyc(0, 0, 0, 2);
        lit("grad_300", 438, 100, 0, 2, 'h2C2C2C);
        lit("grad_0", 138, 100, 0, 2, 0);
        do_reset();
        repeat (7) cyc(0, 0, 0, 3);
        check("fc_before_reset", frame_count, 7);
        check("pat_before_reset", pattern, 3);
        cyc(500, 200, 0, 3);
        do_reset();
        cyc(0, 0, 0, 3);
        lit("box_restart_0", 138, 45, 0, 3, 0);
        lit("box_restart_1", 139, 46, 0, 3, 'hFFFFFF);
        lit("box_restart_32", 170, 77, 0, 3, 'hFFFFFF);
        repeat (448) cyc(0, 0, 0, 3);
        lit("box_y_back_in", 587, 492, 0, 3, 'hFFFFFF);
        lit("box_y_back_out", 587, 491, 0, 3, 0);
        repeat (240) cyc(0, 0, 0, 3);
        lit("box_x_back_in", 825, 252, 0, 3, 'hFFFFFF);
        lit("box_x_back_out", 824, 252, 0, 3, 0);
        lit("box_x_right_out", 857, 252, 0, 3, 0);
        lit("box_x_right_in", 856, 252, 0, 3, 'hFFFFFF);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 1, int'($urandom_range(0, 3)));
            check("auto_seq", pattern, pseq[i]);
        end
        check("auto_fc9", frame_count, 9);
        ac = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 499) == 0) ac = ~ac;
            if ($urandom_range(0, 5) == 0) begin
                x = 0;
                y = 0;
            end else begin
                x = int'($urandom_range(0, 857));
                y = int'($urandom_range(0, 524));
            end
            cyc(x, y, ac, int'($urandom_range(0, 3)));
        end
        done = 1'b0;
        for (int i = 0; i < 70000 && !done; i++) begin
            cyc(0, 0, 1'b1, 0);
            if (m_fc == 65535) check("fc_top", frame_count, 65535);
            if (m_fc == 0) begin
                check("fc_wrap", frame_count, 0);
                done = 1'b1;
            end
        end
        if (!done) check("wrap_timeout", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
